gci_dev_responder: RTL and testbench

GCI_DEV_RESPONDER -- requirements
Module: gci_dev_responder

---
 rtl/gci_dev_responder_if.sv | 31 +++
 rtl/gci_dev_responder.sv | 128 ++++++++++++
 tb/tb_gci_dev_responder.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/gci_dev_responder_if.sv
// Node-side bus of the GCI device responder: request/response channel plus IRQ handshake.
// Signal names match the original flat port list so existing connections map one-to-one.
interface gci_dev_responder_if;
  logic        oNODE_VALID;
  logic        iNODE_REQ;
  logic        oNODE_BUSY;
  logic        iNODE_RW;
  logic [31:0] iNODE_ADDR;
  logic [31:0] iNODE_DATA;
  logic        oNODE_REQ;
  logic        iNODE_BUSY;
  logic [31:0] oNODE_DATA;
  logic        oNODE_IRQ_REQ;
  logic        iNODE_IRQ_BUSY;
  logic [23:0] oNODE_IRQ_DATA;
  logic        iNODE_IRQ_ACK;

  modport master (
    output iNODE_REQ, iNODE_RW, iNODE_ADDR, iNODE_DATA, iNODE_BUSY,
           iNODE_IRQ_BUSY, iNODE_IRQ_ACK,
    input  oNODE_VALID, oNODE_BUSY, oNODE_REQ, oNODE_DATA,
           oNODE_IRQ_REQ, oNODE_IRQ_DATA
  );

  modport slave (
    input  iNODE_REQ, iNODE_RW, iNODE_ADDR, iNODE_DATA, iNODE_BUSY,
           iNODE_IRQ_BUSY, iNODE_IRQ_ACK,
    output oNODE_VALID, oNODE_BUSY, oNODE_REQ, oNODE_DATA,
           oNODE_IRQ_REQ, oNODE_IRQ_DATA
  );
endinterface

// File: rtl/gci_dev_responder.sv
// GCI device responder: small register file (ID, INTFLAG/MASK, 16 scratch words)
// answering node requests after a fixed latency, plus a pending-flag interrupt source.
module gci_dev_responder #(
  parameter logic [31:0] MEMSIZE      = 32'h0000_1000,
  parameter logic [7:0]  PRIORITY     = 8'h01,
  parameter logic [3:0]  RESP_LATENCY = 4'h1
) (
  input  logic               iCLOCK,
  input  logic               inRESET,
  input  logic [23:0]        iEVENT,
  gci_dev_responder_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} dataState_t;
  typedef enum logic [1:0] {I_IDLE, I_ASSERT, I_ACKED} irqState_t;

  dataState_t  dataState, dataNext;
  irqState_t   irqState, irqNext;
  logic        valid;
  logic        reqRw;
  logic [29:0] reqWord;
  logic [29:0] wrWord;
  logic [3:0]  latCnt;
  logic [31:0] respData;
  logic [31:0] rdData;
  logic [23:0] pending, mask, irqData, active, clr;
  logic [31:0] scratch [16];
  logic [4:0]  rdOff, wrOff;
  logic        accept, latchRead, respFire, isIntflagRd;

  assign active      = pending & mask;
  assign wrWord      = bus.iNODE_ADDR[31:2];
  // Word offsets 4..19 map to scratch 0..15; anything else sets bit 4 after the subtract.
  assign rdOff       = reqWord[4:0] - 5'd4;
  assign wrOff       = wrWord[4:0] - 5'd4;
  assign accept      = (dataState == IDLE) && valid && bus.iNODE_REQ;
  assign latchRead   = (dataState == WAIT) && (latCnt == '0);
  assign respFire    = (dataState == RESP) && !bus.iNODE_BUSY;
  assign isIntflagRd = !reqRw && (reqWord == 30'd2);
  assign clr         = (latchRead && isIntflagRd) ? active : '0;

  assign bus.oNODE_VALID    = valid;
  assign bus.oNODE_DATA     = respData;
  assign bus.oNODE_IRQ_DATA = irqData;

  always_comb begin
    rdData = '0;
    if (reqWord[29:5] == '0) begin
      case (reqWord[4:0])
        5'd0:    rdData = MEMSIZE;
        5'd1:    rdData = {24'h0, PRIORITY};
        5'd2:    rdData = {8'h0, active};
        5'd3:    rdData = {8'h0, mask};
        default: if (!rdOff[4]) rdData = scratch[rdOff[3:0]];
      endcase
    end
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      dataState <= IDLE;
      irqState  <= I_IDLE;
    end else begin
      dataState <= dataNext;
      irqState  <= irqNext;
    end
  end

  always_comb begin
    dataNext       = dataState;
    bus.oNODE_BUSY = !valid || (dataState != IDLE);
    bus.oNODE_REQ  = 1'b0;
    case (dataState)
      IDLE: if (accept) dataNext = WAIT;
      WAIT: if (latchRead) dataNext = RESP;
      RESP: begin
        bus.oNODE_REQ = !bus.iNODE_BUSY;
        if (respFire) dataNext = IDLE;
      end
      default: dataNext = IDLE;
    endcase
  end

  always_comb begin
    irqNext           = irqState;
    bus.oNODE_IRQ_REQ = (irqState == I_ASSERT);
    if (!bus.iNODE_IRQ_BUSY) begin
      case (irqState)
        I_IDLE:   if (|active) irqNext = I_ASSERT;
        I_ASSERT: if (bus.iNODE_IRQ_ACK) irqNext = I_ACKED;
        I_ACKED:  if (respFire && isIntflagRd) irqNext = I_IDLE;
        default:  irqNext = I_IDLE;
      endcase
    end
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      valid    <= 1'b0;
      reqRw    <= 1'b0;
      reqWord  <= '0;
      latCnt   <= '0;
      respData <= '0;
      pending  <= '0;
      mask     <= '0;
      irqData  <= '0;
      for (int unsigned i = 0; i < 16; i++) scratch[i] <= '0;
    end else begin
      valid   <= 1'b1;
      // Events landing on the INTFLAG clear edge are OR-ed in after the clear.
      pending <= (pending & ~clr) | iEVENT;
      if (accept) begin
        reqRw   <= bus.iNODE_RW;
        reqWord <= wrWord;
        latCnt  <= RESP_LATENCY - 4'd1;
        if (bus.iNODE_RW && (wrWord[29:5] == '0)) begin
          if (wrWord[4:0] == 5'd3) mask <= bus.iNODE_DATA[23:0];
          else if (!wrOff[4]) scratch[wrOff[3:0]] <= bus.iNODE_DATA;
        end
      end else if ((dataState == WAIT) && (latCnt != '0)) begin
        latCnt <= latCnt - 4'd1;
      end
      if (latchRead) respData <= reqRw ? '0 : rdData;
      if ((irqState == I_IDLE) && (irqNext == I_ASSERT)) irqData <= active;
    end
  end

endmodule

// File: tb/tb_gci_dev_responder.sv
// Directed bench for gci_dev_responder: one instance at latency 1, one at latency 3.
module tb_gci_dev_responder;
  logic        clk = 1'b0;
  logic        rstN;
  logic [23:0] ev0, ev3;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  gci_dev_responder_if bus0();
  gci_dev_responder_if bus3();

  gci_dev_responder u0 (.iCLOCK(clk), .inRESET(rstN), .iEVENT(ev0), .bus(bus0));
  gci_dev_responder #(.RESP_LATENCY(4'd3)) u3 (.iCLOCK(clk), .inRESET(rstN), .iEVENT(ev3), .bus(bus3));

  // Called at a negedge; returns at a negedge with u0 idle again.
  task automatic txn0(input logic rw, input logic [31:0] addr, input logic [31:0] wdata,
                      output logic [31:0] rdata, output int lat);
    int n;
    n = 0;
    while (bus0.oNODE_BUSY && n < 50) begin @(negedge clk); n++; end
    bus0.iNODE_RW = rw; bus0.iNODE_ADDR = addr; bus0.iNODE_DATA = wdata; bus0.iNODE_REQ = 1'b1;
    @(negedge clk);
    bus0.iNODE_REQ = 1'b0;
    lat = 0;
    while (!bus0.oNODE_REQ && lat < 40) begin @(negedge clk); lat++; end
    rdata = bus0.oNODE_DATA;
    @(negedge clk);
  endtask

  task automatic waitIrq0(output int n);
    n = 0;
    while (!bus0.oNODE_IRQ_REQ && n < 20) begin @(negedge clk); n++; end
  endtask

  task automatic ack0();
    bus0.iNODE_IRQ_ACK = 1'b1;
    @(negedge clk);
    bus0.iNODE_IRQ_ACK = 1'b0;
  endtask

  task automatic pulse0(input logic [23:0] v);
    ev0 = v;
    @(negedge clk);
    ev0 = '0;
  endtask

  task automatic test_reset();
    rstN = 1'b0; ev0 = '0; ev3 = '0;
    bus0.iNODE_REQ = 0; bus0.iNODE_RW = 0; bus0.iNODE_ADDR = '0; bus0.iNODE_DATA = '0;
    bus0.iNODE_BUSY = 0; bus0.iNODE_IRQ_BUSY = 0; bus0.iNODE_IRQ_ACK = 0;
    bus3.iNODE_REQ = 0; bus3.iNODE_RW = 0; bus3.iNODE_ADDR = '0; bus3.iNODE_DATA = '0;
    bus3.iNODE_BUSY = 0; bus3.iNODE_IRQ_BUSY = 0; bus3.iNODE_IRQ_ACK = 0;
    @(negedge clk);
    @(negedge clk);
    tests++; if (bus0.oNODE_VALID !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b expected 0", bus0.oNODE_VALID); end
    tests++; if (bus0.oNODE_BUSY !== 1'b1) begin fails++; $display("FAIL rst_busy: got %b expected 1", bus0.oNODE_BUSY); end
    tests++; if (bus0.oNODE_REQ !== 1'b0 || bus0.oNODE_IRQ_REQ !== 1'b0) begin fails++; $display("FAIL rst_req: got %b/%b expected 0/0", bus0.oNODE_REQ, bus0.oNODE_IRQ_REQ); end
    tests++; if (bus0.oNODE_DATA !== 32'h0 || bus0.oNODE_IRQ_DATA !== 24'h0) begin fails++; $display("FAIL rst_data: got %h/%h expected 0/0", bus0.oNODE_DATA, bus0.oNODE_IRQ_DATA); end
    rstN = 1'b1;
    #1;
    tests++; if (bus0.oNODE_VALID !== 1'b0) begin fails++; $display("FAIL valid_before_edge: got %b expected 0", bus0.oNODE_VALID); end
    @(negedge clk);
    tests++; if (bus0.oNODE_VALID !== 1'b1 || bus0.oNODE_BUSY !== 1'b0) begin fails++; $display("FAIL valid_after_edge: got valid %b busy %b expected 1/0", bus0.oNODE_VALID, bus0.oNODE_BUSY); end
  endtask

  task automatic test_ro_regs();
    logic [31:0] rd; int lat;
    txn0(1'b0, 32'h00, '0, rd, lat);
    tests++; if (rd !== 32'h0000_1000 || lat != 1) begin fails++; $display("FAIL memsize: got %h lat %0d expected 00001000 lat 1", rd, lat); end
    txn0(1'b0, 32'h04, '0, rd, lat);
    tests++; if (rd !== 32'h0000_0001 || lat != 1) begin fails++; $display("FAIL priority: got %h lat %0d expected 00000001 lat 1", rd, lat); end
    txn0(1'b1, 32'h00, 32'hFFFF_FFFF, rd, lat);
    tests++; if (rd !== 32'h0 || lat != 1) begin fails++; $display("FAIL ro_write_resp: got %h lat %0d expected 0 lat 1", rd, lat); end
    txn0(1'b0, 32'h00, '0, rd, lat);
    tests++; if (rd !== 32'h0000_1000) begin fails++; $display("FAIL ro_unchanged: got %h expected 00001000", rd); end
  endtask

  task automatic test_scratch();
    logic [31:0] rd; int lat;
    txn0(1'b1, 32'h10, 32'hDEAD_BEEF, rd, lat);
    tests++; if (rd !== 32'h0 || lat != 1) begin fails++; $display("FAIL wr_resp: got %h lat %0d expected 0 lat 1", rd, lat); end
    txn0(1'b0, 32'h10, '0, rd, lat);
    tests++; if (rd !== 32'hDEAD_BEEF) begin fails++; $display("FAIL rd_scratch0: got %h expected deadbeef", rd); end
    txn0(1'b0, 32'h13, '0, rd, lat);
    tests++; if (rd !== 32'hDEAD_BEEF) begin fails++; $display("FAIL addr_low_bits: got %h expected deadbeef", rd); end
    txn0(1'b1, 32'h4C, 32'h1234_5678, rd, lat);
    txn0(1'b0, 32'h4C, '0, rd, lat);
    tests++; if (rd !== 32'h1234_5678) begin fails++; $display("FAIL rd_scratch15: got %h expected 12345678", rd); end
    txn0(1'b1, 32'h50, 32'hA5A5_A5A5, rd, lat);
    txn0(1'b0, 32'h50, '0, rd, lat);
    tests++; if (rd !== 32'h0 || lat != 1) begin fails++; $display("FAIL unmapped: got %h lat %0d expected 0 lat 1", rd, lat); end
    txn0(1'b1, 32'h0C, 32'hFFFF_FFFF, rd, lat);
    txn0(1'b0, 32'h0C, '0, rd, lat);
    tests++; if (rd !== 32'h00FF_FFFF) begin fails++; $display("FAIL mask_width: got %h expected 00ffffff", rd); end
    txn0(1'b1, 32'h0C, 32'h0, rd, lat);
  endtask

  task automatic test_busy_latency();
    int lat; bit ok;
    bus3.iNODE_RW = 1'b0; bus3.iNODE_ADDR = 32'h00; bus3.iNODE_REQ = 1'b1;
    @(negedge clk);
    bus3.iNODE_REQ = 1'b0;
    lat = 0;
    while (!bus3.oNODE_REQ && lat < 40) begin @(negedge clk); lat++; end
    tests++; if (lat != 3 || bus3.oNODE_DATA !== 32'h0000_1000) begin fails++; $display("FAIL lat3: got lat %0d data %h expected 3 00001000", lat, bus3.oNODE_DATA); end
    @(negedge clk);
    bus3.iNODE_BUSY = 1'b1; bus3.iNODE_ADDR = 32'h04; bus3.iNODE_REQ = 1'b1;
    @(negedge clk);
    bus3.iNODE_REQ = 1'b0;
    ok = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      if (c == 2) begin bus3.iNODE_ADDR = 32'h00; bus3.iNODE_REQ = 1'b1; end
      if (c == 4) bus3.iNODE_REQ = 1'b0;
      if (!bus3.oNODE_BUSY || bus3.oNODE_REQ) ok = 1'b0;
      if (c >= 4 && bus3.oNODE_DATA !== 32'h1) ok = 1'b0;
      @(negedge clk);
    end
    tests++; if (!ok) begin fails++; $display("FAIL stall_hold: got ok %b expected 1", ok); end
    bus3.iNODE_BUSY = 1'b0;
    #1;
    tests++; if (bus3.oNODE_REQ !== 1'b1 || bus3.oNODE_DATA !== 32'h1 || bus3.oNODE_BUSY !== 1'b1) begin fails++; $display("FAIL stall_release: got req %b data %h busy %b expected 1 1 1", bus3.oNODE_REQ, bus3.oNODE_DATA, bus3.oNODE_BUSY); end
    @(negedge clk);
    tests++; if (bus3.oNODE_REQ !== 1'b0 || bus3.oNODE_BUSY !== 1'b0) begin fails++; $display("FAIL back_idle: got req %b busy %b expected 0/0", bus3.oNODE_REQ, bus3.oNODE_BUSY); end
    ok = 1'b1;
    repeat (6) begin if (bus3.oNODE_REQ) ok = 1'b0; @(negedge clk); end
    tests++; if (!ok) begin fails++; $display("FAIL ignored_req: got extra response, expected none"); end
  endtask

  task automatic test_irq();
    logic [31:0] rd; int lat; int n;
    bus0.iNODE_IRQ_BUSY = 1'b1;
    txn0(1'b1, 32'h0C, 32'h1, rd, lat);
    pulse0(24'h1);
    repeat (3) @(negedge clk);
    tests++; if (bus0.oNODE_IRQ_REQ !== 1'b0) begin fails++; $display("FAIL irq_frozen: got %b expected 0", bus0.oNODE_IRQ_REQ); end
    bus0.iNODE_IRQ_BUSY = 1'b0;
    waitIrq0(n);
    tests++; if (bus0.oNODE_IRQ_REQ !== 1'b1 || bus0.oNODE_IRQ_DATA !== 24'h1) begin fails++; $display("FAIL irq_assert: got req %b data %h expected 1 000001", bus0.oNODE_IRQ_REQ, bus0.oNODE_IRQ_DATA); end
    ack0();
    tests++; if (bus0.oNODE_IRQ_REQ !== 1'b0) begin fails++; $display("FAIL irq_acked: got %b expected 0", bus0.oNODE_IRQ_REQ); end
    txn0(1'b0, 32'h08, '0, rd, lat);
    tests++; if (rd !== 32'h1) begin fails++; $display("FAIL intflag_rd: got %h expected 1", rd); end
    txn0(1'b0, 32'h08, '0, rd, lat);
    tests++; if (rd !== 32'h0 || bus0.oNODE_IRQ_REQ !== 1'b0) begin fails++; $display("FAIL intflag_cleared: got %h irq %b expected 0 0", rd, bus0.oNODE_IRQ_REQ); end
  endtask

  task automatic test_clear_race();
    int n;
    pulse0(24'h1);
    waitIrq0(n);
    ack0();
    bus0.iNODE_RW = 1'b0; bus0.iNODE_ADDR = 32'h08; bus0.iNODE_REQ = 1'b1;
    @(negedge clk);
    bus0.iNODE_REQ = 1'b0; ev0 = 24'h1;
    @(negedge clk);
    ev0 = '0;
    tests++; if (bus0.oNODE_REQ !== 1'b1 || bus0.oNODE_DATA !== 32'h1) begin fails++; $display("FAIL race_rd: got req %b data %h expected 1 1", bus0.oNODE_REQ, bus0.oNODE_DATA); end
    @(negedge clk);
    waitIrq0(n);
    tests++; if (bus0.oNODE_IRQ_REQ !== 1'b1 || bus0.oNODE_IRQ_DATA !== 24'h1) begin fails++; $display("FAIL race_reirq: got req %b data %h expected 1 000001", bus0.oNODE_IRQ_REQ, bus0.oNODE_IRQ_DATA); end
  endtask

  task automatic test_mask_clear();
    logic [31:0] rd; int lat; int n;
    txn0(1'b1, 32'h0C, 32'h0, rd, lat);
    tests++; if (bus0.oNODE_IRQ_REQ !== 1'b1) begin fails++; $display("FAIL mask_clr_hold: got %b expected 1", bus0.oNODE_IRQ_REQ); end
    ack0();
    txn0(1'b0, 32'h08, '0, rd, lat);
    tests++; if (rd !== 32'h0) begin fails++; $display("FAIL masked_rd: got %h expected 0", rd); end
    repeat (3) @(negedge clk);
    tests++; if (bus0.oNODE_IRQ_REQ !== 1'b0) begin fails++; $display("FAIL masked_quiet: got %b expected 0", bus0.oNODE_IRQ_REQ); end
    txn0(1'b1, 32'h0C, 32'h1, rd, lat);
    waitIrq0(n);
    tests++; if (bus0.oNODE_IRQ_REQ !== 1'b1 || bus0.oNODE_IRQ_DATA !== 24'h1) begin fails++; $display("FAIL unmask_irq: got req %b data %h expected 1 000001", bus0.oNODE_IRQ_REQ, bus0.oNODE_IRQ_DATA); end
    ack0();
    txn0(1'b0, 32'h08, '0, rd, lat);
    tests++; if (rd !== 32'h1) begin fails++; $display("FAIL unmask_rd: got %h expected 1", rd); end
  endtask

  task automatic test_reset_midtxn();
    logic [31:0] rd; int lat; int n; bit ok;
    txn0(1'b1, 32'h0C, 32'h20, rd, lat);
    pulse0(24'h20);
    waitIrq0(n);
    bus0.iNODE_RW = 1'b0; bus0.iNODE_ADDR = 32'h10; bus0.iNODE_REQ = 1'b1;
    @(negedge clk);
    bus0.iNODE_REQ = 1'b0;
    rstN = 1'b0;
    #1;
    tests++; if (bus0.oNODE_REQ !== 1'b0 || bus0.oNODE_BUSY !== 1'b1 || bus0.oNODE_IRQ_REQ !== 1'b0) begin fails++; $display("FAIL midrst_out: got req %b busy %b irq %b expected 0 1 0", bus0.oNODE_REQ, bus0.oNODE_BUSY, bus0.oNODE_IRQ_REQ); end
    @(negedge clk);
    @(negedge clk);
    rstN = 1'b1;
    ok = 1'b1;
    repeat (6) begin @(negedge clk); if (bus0.oNODE_REQ) ok = 1'b0; end
    tests++; if (!ok) begin fails++; $display("FAIL midrst_noresp: got a response, expected none"); end
    tests++; if (bus0.oNODE_IRQ_DATA !== 24'h0) begin fails++; $display("FAIL midrst_irqdata: got %h expected 0", bus0.oNODE_IRQ_DATA); end
    txn0(1'b0, 32'h0C, '0, rd, lat);
    tests++; if (rd !== 32'h0) begin fails++; $display("FAIL midrst_mask: got %h expected 0", rd); end
    txn0(1'b0, 32'h10, '0, rd, lat);
    tests++; if (rd !== 32'h0) begin fails++; $display("FAIL midrst_scr0: got %h expected 0", rd); end
    txn0(1'b0, 32'h4C, '0, rd, lat);
    tests++; if (rd !== 32'h0) begin fails++; $display("FAIL midrst_scr15: got %h expected 0", rd); end
    txn0(1'b1, 32'h0C, 32'hFF_FFFF, rd, lat);
    txn0(1'b0, 32'h08, '0, rd, lat);
    tests++; if (rd !== 32'h0 || bus0.oNODE_IRQ_REQ !== 1'b0) begin fails++; $display("FAIL midrst_pending: got %h irq %b expected 0 0", rd, bus0.oNODE_IRQ_REQ); end
  endtask

  initial begin
    test_reset();
    test_ro_regs();
    test_scratch();
    test_busy_latency();
    test_irq();
    test_clear_race();
    test_mask_clear();
    test_reset_midtxn();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
